// File: rtl/panel_ctrl_arbiter.sv
// panel_ctrl_arbiter
// Two-requester write arbiter for the shared panel control bus. Requester 0 is
// the UDP panel writer and requester 1 is a local pattern/animation source.
// Ownership is locked for a whole packet (until the beat flagged last). The
// requester not served most recently wins a tie. Bus outputs are registered
// with one cycle of latency.
// Optional feature: define PANEL_CTRL_ARB_TIMEOUT_EN to add a stall watchdog.
// The watchdog force-releases a grant after TIMEOUT consecutive idle cycles
// and pulses timeout_err when it does.

module panel_ctrl_arbiter #(
  parameter int EN_W    = 8,
  parameter int WR_W    = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 24,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              rq0_valid,
  output logic              rq0_ready,
  input  logic              rq0_last,
  input  logic [EN_W-1:0]   rq0_en,
  input  logic [WR_W-1:0]   rq0_wr,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_wdat,

  input  logic              rq1_valid,
  output logic              rq1_ready,
  input  logic              rq1_last,
  input  logic [EN_W-1:0]   rq1_en,
  input  logic [WR_W-1:0]   rq1_wr,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_wdat,

  output logic [EN_W-1:0]   ctrl_en,
  output logic [WR_W-1:0]   ctrl_wr,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic [DATA_W-1:0] ctrl_wdat,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // rr_ptr = 0 favours rq0 on a tie, rr_ptr = 1 favours rq1
  logic rr_ptr;
  logic rr_next;

  // Signals of whichever requester currently owns the bus
  logic              sel_valid;
  logic              sel_last;
  logic [EN_W-1:0]   sel_en;
  logic [WR_W-1:0]   sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdat;

  logic beat_acc;
  logic timeout_hit;

  // Ready and grant come from the state only, so a requester cannot
  // combinationally loop valid back into ready
  assign rq0_ready = (state == GNT0);
  assign rq1_ready = (state == GNT1);
  assign grant     = {(state == GNT1), (state == GNT0)};

  // Route the owning requester's beat toward the bus register
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_en    = '0;
    sel_wr    = '0;
    sel_addr  = '0;
    sel_wdat  = '0;
    case (state)
      GNT0: begin
        sel_valid = rq0_valid;
        sel_last  = rq0_last;
        sel_en    = rq0_en;
        sel_wr    = rq0_wr;
        sel_addr  = rq0_addr;
        sel_wdat  = rq0_wdat;
      end
      GNT1: begin
        sel_valid = rq1_valid;
        sel_last  = rq1_last;
        sel_en    = rq1_en;
        sel_wr    = rq1_wr;
        sel_addr  = rq1_addr;
        sel_wdat  = rq1_wdat;
      end
      default: ;
    endcase
  end

  assign beat_acc = sel_valid;

`ifdef PANEL_CTRL_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] stall_cnt;

  // The TIMEOUT-th consecutive stall cycle inside a grant forces a release
  assign timeout_hit = (state != IDLE) && !sel_valid &&
                       (stall_cnt == CNT_W'(TIMEOUT - 1));

  // Count stall cycles inside a grant; the IDLE pass before every grant clears it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (state == IDLE || beat_acc || timeout_hit) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // One-cycle error pulse that lines up with the forced return to IDLE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next state and round-robin pointer
  always_comb begin
    state_next = state;
    rr_next    = rr_ptr;
    case (state)
      IDLE: begin
        if (rq0_valid && (!rq1_valid || !rr_ptr)) begin
          state_next = GNT0;
        end else if (rq1_valid) begin
          state_next = GNT1;
        end
      end
      GNT0: begin
        if ((beat_acc && sel_last) || timeout_hit) begin
          state_next = IDLE;
          rr_next    = 1'b1;
        end
      end
      GNT1: begin
        if ((beat_acc && sel_last) || timeout_hit) begin
          state_next = IDLE;
          rr_next    = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and round-robin registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
    end else begin
      state  <= state_next;
      rr_ptr <= rr_next;
    end
  end

  // Bus register: strobes only on accepted beats, while address and data hold
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_en   <= '0;
      ctrl_wr   <= '0;
      ctrl_addr <= '0;
      ctrl_wdat <= '0;
    end else if (beat_acc) begin
      ctrl_en   <= sel_en;
      ctrl_wr   <= sel_wr;
      ctrl_addr <= sel_addr;
      ctrl_wdat <= sel_wdat;
    end else begin
      ctrl_en   <= '0;
      ctrl_wr   <= '0;
    end
  end

endmodule
